// File: rtl/rtlinf_pkg.sv
// Shared widths and FSM encoding for the
// streaming multiply/clip inference engine.
package rtlinf_pkg;

  localparam int P_GROUP_SIZE  = 4;
  localparam int P_DATA_WIDTH  = 8;
  localparam int P_NUM_INPUTS  = 9;
  localparam int P_NUM_LANES   = 9;
  localparam int P_NUM_OUTPUTS = 9;
  localparam int P_LOG_ITERS   = 8;
  localparam int P_LOG_READS   = 8;
  localparam int P_LOG_ADDR    = 12;
  localparam int P_NUM_ADDR    = 4096;

  localparam int ACC_W  =
    2 * P_DATA_WIDTH + $clog2(P_NUM_LANES);
  localparam int WORD_W =
    P_GROUP_SIZE * P_DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

endpackage

// File: rtl/rtlinf_lane.sv
// One compute lane: every group element
// times the lane weight, full-width unsigned.
module rtlinf_lane
  import rtlinf_pkg::*;
#(
  parameter int GROUP_SIZE = P_GROUP_SIZE,
  parameter int DATA_WIDTH = P_DATA_WIDTH
) (
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0]   act,
  input  logic [DATA_WIDTH-1:0]              weight,
  output logic [GROUP_SIZE*2*DATA_WIDTH-1:0] prod
);

  localparam int PW = 2 * DATA_WIDTH;

  always_comb begin
    prod = '0;
    for (int g = 0; g < GROUP_SIZE; g++) begin
      prod[g*PW +: PW] =
        PW'(act[g*DATA_WIDTH +: DATA_WIDTH]) *
        PW'(weight);
    end
  end

endmodule

// File: rtl/rtlinf_core.sv
// Streaming multiply/clip engine: issues one
// act/weight read per cycle, writes 2 cycles later.
module rtlinf_core
  import rtlinf_pkg::*;
#(
  parameter int GROUP_SIZE             = P_GROUP_SIZE,
  parameter int DATA_WIDTH             = P_DATA_WIDTH,
  parameter int NUM_INPUTS             = P_NUM_INPUTS,
  parameter int NUM_LANES              = P_NUM_LANES,
  parameter int NUM_OUTPUTS            = P_NUM_OUTPUTS,
  parameter int LOG_MAX_ITERS          = P_LOG_ITERS,
  parameter int LOG_MAX_READS_PER_ITER = P_LOG_READS,
  parameter int LOG_MAX_ADDRESS        = P_LOG_ADDR,
  parameter int NUM_ADDRESSES          = P_NUM_ADDR
) (
  input  logic clk,
  input  logic rst,
  output logic [NUM_INPUTS-1:0] act_read,
  output logic [NUM_INPUTS*LOG_MAX_ADDRESS-1:0] act_addr,
  input  logic [NUM_INPUTS*GROUP_SIZE*DATA_WIDTH-1:0] act_data,
  input  logic [NUM_INPUTS-1:0] act_valid,
  output logic weight_read,
  output logic [LOG_MAX_ADDRESS-1:0] weight_addr,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] weight_data,
  input  logic weight_valid,
  input  logic configure,
  input  logic [LOG_MAX_ITERS-1:0] num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
  input  logic [LOG_MAX_ADDRESS-1:0] read_address,
  input  logic [LOG_MAX_ADDRESS-1:0] write_address,
  input  logic conf_mode_in,
  input  logic conf_mode_out,
  input  logic [DATA_WIDTH-1:0] min_clip,
  input  logic [DATA_WIDTH-1:0] max_clip,
  output logic [NUM_OUTPUTS*GROUP_SIZE*DATA_WIDTH-1:0] data_out,
  output logic [NUM_OUTPUTS*LOG_MAX_ADDRESS-1:0] addr_out,
  output logic [NUM_OUTPUTS-1:0] valid_out
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DW;
  localparam int SW = PW + $clog2(NUM_LANES);
  localparam int WW = GROUP_SIZE * DW;
  localparam int AW = LOG_MAX_ADDRESS;
  localparam int LI = LOG_MAX_ITERS;
  localparam int LR = LOG_MAX_READS_PER_ITER;
  localparam int OW = NUM_OUTPUTS * WW;
  localparam int OA = NUM_OUTPUTS * AW;
  localparam logic [AW-1:0] ADDR_MASK =
    AW'(NUM_ADDRESSES - 1);

  state_e state_q, state_d;
  logic [LI-1:0] iters_q, iters_d;
  logic [LI-1:0] it_q, it_d;
  logic [LR-1:0] reads_q, reads_d;
  logic [LR-1:0] r_q, r_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] o_q, o_d;
  logic mode_in_q, mode_in_d;
  logic mode_out_q, mode_out_d;
  logic [DW-1:0] min_q, min_d;
  logic [DW-1:0] max_q, max_d;
  logic [1:0] infl_q, infl_d;
  logic [OW-1:0] data_q, data_d;
  logic [OA-1:0] addr_q, addr_d;
  logic [NUM_OUTPUTS-1:0] valid_q, valid_d;

  logic issue;
  logic consume;
  logic need_valid;
  logic r_last;
  logic it_last;
  logic [AW-1:0] aaddr;
  logic [WW-1:0] lane_act [NUM_LANES];
  logic [GROUP_SIZE*PW-1:0] prod [NUM_LANES];
  logic [SW-1:0] sum_v [GROUP_SIZE];
  logic [OW-1:0] res;

  function automatic logic [DW-1:0] clip(
    input logic [SW-1:0] x,
    input logic [DW-1:0] lo,
    input logic [DW-1:0] hi
  );
    if (x < SW'(lo)) return lo;
    if (x > SW'(hi)) return hi;
    return x[DW-1:0];
  endfunction

  assign issue  = (state_q == S_RUN);
  assign r_last = (r_q == reads_q - LR'(1));
  assign it_last = (it_q == iters_q - LI'(1));
  assign aaddr  = (raddr_q + AW'(r_q)) & ADDR_MASK;

  assign need_valid = mode_in_q ? &act_valid
                                : act_valid[0];
  assign consume = (state_q != S_IDLE) &&
                   need_valid && weight_valid;

  // Mode 0 reads only input 0 and broadcasts it
  assign act_read = !issue    ? '0 :
                    mode_in_q ? '1 :
                    NUM_INPUTS'(1);
  assign act_addr = issue ? {NUM_INPUTS{aaddr}}
                          : '0;
  assign weight_read = issue;
  assign weight_addr = issue ? k_q : '0;

  assign data_out  = data_q;
  assign addr_out  = addr_q;
  assign valid_out = valid_q;

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_act[l] = mode_in_q ?
        act_data[l*WW +: WW] : act_data[WW-1:0];
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin
    : g_lane
    rtlinf_lane #(
      .GROUP_SIZE (GROUP_SIZE),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .act    (lane_act[l]),
      .weight (weight_data[l*DW +: DW]),
      .prod   (prod[l])
    );
  end

  always_comb begin
    for (int g = 0; g < GROUP_SIZE; g++) begin
      sum_v[g] = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        sum_v[g] = sum_v[g] +
          SW'(prod[l][g*PW +: PW]);
      end
    end
  end

  always_comb begin
    res = '0;
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      for (int g = 0; g < GROUP_SIZE; g++) begin
        res[o*WW + g*DW +: DW] = mode_out_q ?
          clip(SW'(prod[o][g*PW +: PW]),
               min_q, max_q) :
          clip(sum_v[g], min_q, max_q);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    iters_d    = iters_q;
    it_d       = it_q;
    reads_d    = reads_q;
    r_d        = r_q;
    raddr_d    = raddr_q;
    waddr_d    = waddr_q;
    k_d        = k_q;
    o_d        = o_q;
    mode_in_d  = mode_in_q;
    mode_out_d = mode_out_q;
    min_d      = min_q;
    max_d      = max_q;
    infl_d     = infl_q + {1'b0, issue}
                        - {1'b0, consume};
    data_d     = data_q;
    addr_d     = addr_q;
    valid_d    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (configure) begin
          state_d    = S_RUN;
          iters_d    = num_iters;
          reads_d    = num_reads_per_iter;
          raddr_d    = read_address;
          waddr_d    = write_address;
          mode_in_d  = conf_mode_in;
          mode_out_d = conf_mode_out;
          min_d      = min_clip;
          max_d      = max_clip;
          it_d       = '0;
          r_d        = '0;
          k_d        = '0;
          o_d        = '0;
        end
      end
      S_RUN: begin
        // k is the global op index, equal to it*reads+r
        k_d = (k_q + AW'(1)) & ADDR_MASK;
        if (r_last) begin
          r_d = '0;
          if (it_last) state_d = S_DRAIN;
          else it_d = it_q + LI'(1);
        end else begin
          r_d = r_q + LR'(1);
        end
      end
      S_DRAIN: begin
        if (infl_q == 2'd0 && !consume)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (consume) begin
      valid_d = '1;
      data_d  = res;
      o_d     = (o_q + AW'(1)) & ADDR_MASK;
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        addr_d[o*AW +: AW] =
          (waddr_q + o_q) & ADDR_MASK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      iters_q    <= '0;
      it_q       <= '0;
      reads_q    <= '0;
      r_q        <= '0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      k_q        <= '0;
      o_q        <= '0;
      mode_in_q  <= 1'b0;
      mode_out_q <= 1'b0;
      min_q      <= '0;
      max_q      <= '0;
      infl_q     <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      iters_q    <= iters_d;
      it_q       <= it_d;
      reads_q    <= reads_d;
      r_q        <= r_d;
      raddr_q    <= raddr_d;
      waddr_q    <= waddr_d;
      k_q        <= k_d;
      o_q        <= o_d;
      mode_in_q  <= mode_in_d;
      mode_out_q <= mode_out_d;
      min_q      <= min_d;
      max_q      <= max_d;
      infl_q     <= infl_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_rtlinf_core.sv
// Bench for rtlinf_core: SRAM models, scenario
// table and a queue-based reference model.
module tb_rtlinf_core;
  import rtlinf_pkg::*;

  localparam int NI = 9;
  localparam int NL = 9;
  localparam int NO = 9;
  localparam int G  = 4;
  localparam int DW = 8;
  localparam int AW = 12;
  localparam int WW = G * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NI-1:0] act_read;
  logic [NI*AW-1:0] act_addr;
  logic [NI*WW-1:0] act_data = '0;
  logic [NI-1:0] act_valid = '0;
  logic weight_read;
  logic [AW-1:0] weight_addr;
  logic [NL*DW-1:0] weight_data = '0;
  logic weight_valid = 1'b0;
  logic configure = 1'b0;
  logic [7:0] num_iters = '0;
  logic [7:0] num_reads_per_iter = '0;
  logic [AW-1:0] read_address = '0;
  logic [AW-1:0] write_address = '0;
  logic conf_mode_in = 1'b0;
  logic conf_mode_out = 1'b0;
  logic [DW-1:0] min_clip = '0;
  logic [DW-1:0] max_clip = '0;
  logic [NO*WW-1:0] data_out;
  logic [NO*AW-1:0] addr_out;
  logic [NO-1:0] valid_out;

  rtlinf_core dut (
    .clk (clk), .rst (rst),
    .act_read (act_read), .act_addr (act_addr),
    .act_data (act_data), .act_valid (act_valid),
    .weight_read (weight_read),
    .weight_addr (weight_addr),
    .weight_data (weight_data),
    .weight_valid (weight_valid),
    .configure (configure),
    .num_iters (num_iters),
    .num_reads_per_iter (num_reads_per_iter),
    .read_address (read_address),
    .write_address (write_address),
    .conf_mode_in (conf_mode_in),
    .conf_mode_out (conf_mode_out),
    .min_clip (min_clip), .max_clip (max_clip),
    .data_out (data_out), .addr_out (addr_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int iters; int reads; int ra; int wa;
    bit mi; bit mo; int lo; int hi; int pat;
    int exp_cnt; int exp_first; int exp_last;
    bit poke;
  } vec_t;
  typedef struct {
    logic [AW-1:0] aa; logic [AW-1:0] wa;
  } iss_t;
  typedef struct {
    logic [AW-1:0] addr; logic [NO*WW-1:0] data;
  } wr_t;

  logic [WW-1:0] act_mem [NI][4096];
  logic [NL*DW-1:0] wt_mem [4096];
  iss_t exp_i[$];
  wr_t  exp_w[$];
  int   iss_cyc[$];
  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int nwr = 0;
  int first_data = -1;
  int last_addr = -1;
  bit mon_en = 1'b0;
  bit cur_mi = 1'b0;

  // single-cycle-latency SRAM wrappers
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NI; i++) begin
      act_valid[i] <= act_read[i];
      if (act_read[i])
        act_data[i*WW +: WW] <=
          act_mem[i][act_addr[i*AW +: AW]];
    end
    weight_valid <= weight_read;
    if (weight_read)
      weight_data <= wt_mem[weight_addr];
  end

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h",
               nm, a, e);
    end
  endtask

  function automatic int clipv(int x, int lo,
                               int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  task automatic fill(input int pat);
    logic [7:0] b;
    logic [95:0] t;
    for (int a = 0; a < 4096; a++) begin
      b = 8'(a + 1);
      for (int i = 0; i < NI; i++) begin
        case (pat)
          0: act_mem[i][a] = {4{b}};
          1: act_mem[i][a] = {4{8'd200}};
          2: act_mem[i][a] = (i == 0) ?
               {4{8'd10}} : {4{8'd77}};
          default: act_mem[i][a] = $urandom();
        endcase
      end
      t = {$urandom(), $urandom(), $urandom()};
      case (pat)
        0: wt_mem[a] = {9{8'd2}};
        1: wt_mem[a] = {9{8'd200}};
        2: wt_mem[a] = {9{8'd3}};
        default: wt_mem[a] = t[NL*DW-1:0];
      endcase
    end
  endtask

  // Reference: walk op index k over the whole run
  task automatic build(input vec_t v);
    int ni, nr, n;
    ni = (v.iters == 0) ? 256 : v.iters;
    nr = (v.reads == 0) ? 256 : v.reads;
    n = ni * nr;
    exp_i.delete(); exp_w.delete();
    iss_cyc.delete();
    for (int k = 0; k < n; k++) begin
      int it, r, aa, wa, ad, s, val;
      int p [NL][G];
      iss_t is;
      wr_t w;
      it = k / nr;
      r = k % nr;
      aa = (v.ra + r) % 4096;
      wa = (it * nr + r) % 4096;
      ad = (v.wa + k) % 4096;
      is.aa = aa[AW-1:0];
      is.wa = wa[AW-1:0];
      exp_i.push_back(is);
      for (int l = 0; l < NL; l++)
        for (int g = 0; g < G; g++)
          p[l][g] =
            int'(act_mem[v.mi ? l : 0][aa]
                 [g*DW +: DW]) *
            int'(wt_mem[wa][l*DW +: DW]);
      w.addr = ad[AW-1:0];
      w.data = '0;
      for (int g = 0; g < G; g++) begin
        s = 0;
        for (int l = 0; l < NL; l++)
          s += p[l][g];
        for (int o = 0; o < NO; o++) begin
          val = v.mo ? clipv(p[o][g], v.lo, v.hi)
                     : clipv(s, v.lo, v.hi);
          w.data[(o*G+g)*DW +: DW] = val[7:0];
        end
      end
      exp_w.push_back(w);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && weight_read) begin
      iss_t e;
      bit ok;
      logic [NI-1:0] m;
      nvec++;
      if (exp_i.size() == 0) begin
        nerr++;
        $display("FAIL extra_issue: waddr %0h",
                 weight_addr);
      end else begin
        e = exp_i.pop_front();
        m = cur_mi ? '1 : NI'(1);
        ok = (weight_addr === e.wa) &&
             (act_read === m);
        for (int i = 0; i < NI; i++)
          if (m[i] &&
              act_addr[i*AW +: AW] !== e.aa)
            ok = 1'b0;
        if (!ok) begin
          nerr++;
          $display({"FAIL issue: rd %0h aaddr",
            " %0h waddr %0h want rd %0h aaddr",
            " %0h waddr %0h"}, act_read,
            act_addr[AW-1:0], weight_addr, m,
            e.aa, e.wa);
        end
      end
      iss_cyc.push_back(cyc);
    end
    if (mon_en && |valid_out) begin
      wr_t e;
      int lat;
      bit aok;
      nvec++;
      if (exp_w.size() == 0) begin
        nerr++;
        $display("FAIL extra_write: addr %0h",
                 addr_out[AW-1:0]);
      end else begin
        e = exp_w.pop_front();
        lat = (iss_cyc.size() > 0) ?
              cyc - iss_cyc.pop_front() : -1;
        aok = 1'b1;
        for (int o = 0; o < NO; o++)
          if (addr_out[o*AW +: AW] !== e.addr)
            aok = 1'b0;
        if (valid_out !== '1 || !aok ||
            data_out !== e.data || lat != 2)
        begin
          nerr++;
          $display({"FAIL write[%0d]: valid %0h",
            " addr %0h lat %0d data %0h want",
            " addr %0h lat 2 data %0h"}, nwr,
            valid_out, addr_out[AW-1:0], lat,
            data_out, e.addr, e.data);
        end
        if (nwr == 0)
          first_data = int'(data_out[7:0]);
        last_addr = int'(addr_out[AW-1:0]);
        nwr++;
      end
    end
  end

  task automatic drive_cfg(input vec_t v);
    num_iters = 8'(v.iters);
    num_reads_per_iter = 8'(v.reads);
    read_address = AW'(v.ra);
    write_address = AW'(v.wa);
    conf_mode_in = v.mi;
    conf_mode_out = v.mo;
    min_clip = 8'(v.lo);
    max_clip = 8'(v.hi);
  endtask

  task automatic run_vec(input vec_t v,
                         input string nm);
    int budget;
    fill(v.pat);
    build(v);
    budget = exp_w.size() + 20;
    cur_mi = v.mi;
    nwr = 0;
    first_data = -1;
    last_addr = -1;
    mon_en = 1'b1;
    @(negedge clk);
    drive_cfg(v);
    configure = 1'b1;
    @(negedge clk);
    configure = 1'b0;
    #1;
    chk({nm, "_first_issue"}, 64'(weight_read), 1);
    for (int c = 0; c < budget; c++) begin
      if (exp_w.size() == 0 && exp_i.size() == 0)
        break;
      if (v.poke && c == 10) begin
        configure = 1'b1;
        read_address = read_address ^ 12'h555;
        conf_mode_in = ~conf_mode_in;
      end else begin
        configure = 1'b0;
      end
      @(negedge clk);
      #1;
    end
    configure = 1'b0;
    chk({nm, "_pending"},
        64'(exp_w.size() + exp_i.size()), 0);
    @(negedge clk);
    #1;
    chk({nm, "_idle"}, 64'(dut.state_q),
        64'(S_IDLE));
    repeat (3) @(negedge clk);
    chk({nm, "_count"}, 64'(nwr), 64'(v.exp_cnt));
    chk({nm, "_last_addr"}, 64'(last_addr),
        64'(v.exp_last));
    if (v.exp_first >= 0)
      chk({nm, "_first_data"}, 64'(first_data),
          64'(v.exp_first));
  endtask

  function automatic bit all_zero();
    return act_read == '0 && act_addr == '0 &&
           weight_read == 1'b0 &&
           weight_addr == '0 && data_out == '0 &&
           addr_out == '0 && valid_out == '0;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    vec_t v;
    int n5;
    tbl[0] = '{1, 4, 0, 16, 1, 1, 0, 255, 0,
               4, 2, 19, 0};
    tbl[1] = '{1, 4, 0, 16, 1, 1, 3, 5, 0,
               4, 3, 19, 0};
    tbl[2] = '{1, 2, 0, 16, 1, 1, 3, 5, 1,
               2, 5, 17, 0};
    tbl[3] = '{1, 3, 0, 40, 0, 0, 0, 255, 2,
               3, 255, 42, 0};
    tbl[4] = '{2, 0, 0, 100, 1, 1, 0, 255, 3,
               512, -1, 611, 1};
    tbl[5] = '{1, 3, 4094, 4095, 1, 1, 0, 255, 0,
               3, 255, 1, 0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", 64'(all_zero()), 1);
    rst = 1'b0;

    for (int t = 0; t < 6; t++)
      run_vec(tbl[t], $sformatf("tbl%0d", t));

    for (int j = 0; j < 4; j++) begin
      v.iters = $urandom_range(1, 3);
      v.reads = $urandom_range(1, 16);
      v.ra = $urandom_range(0, 4095);
      v.wa = $urandom_range(0, 4095);
      v.mi = j[0];
      v.mo = j[1];
      v.lo = $urandom_range(0, 60);
      v.hi = v.lo + $urandom_range(0, 190);
      v.pat = 3;
      v.exp_cnt = v.iters * v.reads;
      v.exp_first = -1;
      v.exp_last = (v.wa + v.exp_cnt - 1) % 4096;
      v.poke = 1'b0;
      run_vec(v, $sformatf("rnd%0d", j));
    end

    // reset in the middle of a run
    mon_en = 1'b0;
    v = tbl[0];
    v.reads = 20;
    fill(0);
    @(negedge clk);
    drive_cfg(v);
    configure = 1'b1;
    @(negedge clk);
    configure = 1'b0;
    n5 = 0;
    for (int c = 0; c < 30 && n5 < 5; c++) begin
      if (weight_read) n5++;
      if (n5 < 5) @(negedge clk);
    end
    chk("rst_five_issues", 64'(n5), 5);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_outputs_zero", 64'(all_zero()), 1);
    chk("rst_state", 64'(dut.state_q),
        64'(S_IDLE));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_discard", 64'(all_zero()), 1);
    repeat (3) @(negedge clk);
    chk("rst_quiet", 64'(all_zero()), 1);
    run_vec(tbl[0], "restart");

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rtlinf_core.md
Name: rtlinf_core

Overview:
- Streaming multiply/clip inference engine.
- Reads activation groups from NUM_INPUTS external activation memories and per-lane weights from one weight memory. Each lane multiplies every group element by its own weight, clips the result, and writes it to NUM_OUTPUTS external output memories.
- Sits between single-cycle-latency SRAM wrappers. It is configured by a one-cycle pulse and then runs autonomously.

Parameters:
- GROUP_SIZE, 4: elements per activation/output word.
- DATA_WIDTH, 8: element width (unsigned).
- NUM_INPUTS, 9: activation memory ports.
- NUM_LANES, 9: compute lanes, one weight byte each.
- NUM_OUTPUTS, 9: output memory ports.
- LOG_MAX_ITERS, 8: width of num_iters.
- LOG_MAX_READS_PER_ITER, 8: width of num_reads_per_iter.
- LOG_MAX_ADDRESS, 12: address width.
- NUM_ADDRESSES, 4096: memory depth; must equal 2**LOG_MAX_ADDRESS.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- act_read  out  NUM_INPUTS  per-input read strobe.
- act_addr  out  NUM_INPUTS*LOG_MAX_ADDRESS  per-input read address; slice i belongs to input i.
- act_data  in  NUM_INPUTS*GROUP_SIZE*DATA_WIDTH  per-input read data; element g at bits [g*DW +: DW].
- act_valid  in  NUM_INPUTS  read data valid, one cycle after read.
- weight_read  out  1  weight read strobe.
- weight_addr  out  LOG_MAX_ADDRESS  weight address.
- weight_data  in  NUM_LANES*DATA_WIDTH  weight for lane l at bits [l*DW +: DW].
- weight_valid  in  1  weight data valid.
- configure  in  1  one-cycle start pulse; latches all configuration inputs.
- num_iters  in  LOG_MAX_ITERS  iteration count; 0 means 2**LOG_MAX_ITERS.
- num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  reads per iteration; 0 means 2**LOG_MAX_READS_PER_ITER.
- read_address  in  LOG_MAX_ADDRESS  activation base address.
- write_address  in  LOG_MAX_ADDRESS  output base address.
- conf_mode_in  in  1  0 = input 0 broadcast to all lanes; 1 = input i feeds lane i.
- conf_mode_out  in  1  0 = sum of all lanes sent to every output; 1 = lane i feeds output i.
- min_clip  in  DATA_WIDTH  lower clip bound.
- max_clip  in  DATA_WIDTH  upper clip bound.
- data_out  out  NUM_OUTPUTS*GROUP_SIZE*DATA_WIDTH  write data.
- addr_out  out  NUM_OUTPUTS*LOG_MAX_ADDRESS  write address.
- valid_out  out  NUM_OUTPUTS  write strobe.

Behaviour:
- Reset (synchronous, active-high): FSM goes to IDLE and all outputs are 0, including mid-run; in-flight data is discarded.
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on configure=1. Latch every configuration input and clear counters it (iteration) and r (read index).
- configure asserted in RUN or DRAIN is ignored.
- RUN, one issue per cycle, no stalls:
  - Assert weight_read with weight_addr = it*num_reads + r, mod 2**LOG_MAX_ADDRESS.
  - Assert act_read with act_addr = read_address + r, mod 2**LOG_MAX_ADDRESS.
  - Mode_in 0 drives only input 0; other act_read bits are 0. Mode_in 1 drives all inputs with the same address.
  - r increments each cycle; at r = num_reads-1, r returns to 0 and it increments. After the last issue (it = num_iters-1), go to DRAIN.
- DRAIN: wait until the last result is written, then return to IDLE.
- Consume: a result is computed in the cycle the required act_valid bits and weight_valid are all 1.
- Lane arithmetic (lane l): prod[g] = act[g] * w[l], unsigned, 2*DW bits.
  - Mode_out 1: out[g] = clip(prod[g]).
  - Mode_out 0: out[g] = clip(sum over lanes of prod[g]); the sum is 2*DW+clog2(NUM_LANES) bits.
  - clip(x) = min_clip if x < min_clip; max_clip if x > max_clip; else x[DW-1:0].
- Mode_out 1 requires NUM_INPUTS == NUM_LANES == NUM_OUTPUTS. In mode_in 0, every lane uses input 0's word.
- Writes:
  - data_out, addr_out and valid_out are registered and assert the cycle after consume, i.e. 2 cycles after issue.
  - addr_out = write_address + k, where k = global op index 0..num_iters*num_reads-1, mod 2**LOG_MAX_ADDRESS. All outputs carry the same address.
  - valid_out is all ones for each result; data is identical across outputs in mode_out 0.
- Throughput: one result per cycle. Total writes per output = num_iters*num_reads.

Decomposition:
- Package rtlinf_pkg: width localparams (ACC_W = 2*DW + clog2(NUM_LANES), WORD_W = GROUP_SIZE*DW) and the FSM state enum.
- One sub-module rtlinf_lane: GROUP_SIZE multipliers producing unsigned products. Clipping and reduction stay in the top level.

Test Plan:
- Mode 1/1, iters=1, reads=4, read_address=0, write_address=16; act[i][a] = {a+1,a+1,a+1,a+1}, weights all 2 -> outputs at addresses 16..19 hold 2,4,6,8 in every element, valid 2 cycles after issue.
- Clip: min_clip=3, max_clip=5, same data -> values 3,4,5,5; act=200, w=200 -> 5.
- Mode 0/0 with 9 lanes, act0 element = 10, all weights 3 -> sum 270, max_clip=255 -> all 9 outputs write 255 at the same address.
- Zero-as-max: iters=2, reads=0 -> 512 writes, act addresses wrap 0..255 twice, weight addresses 0..511, output addresses write_address..+511.
- Address wrap: read_address=4094, write_address=4095, reads=3 -> act addresses 4094,4095,0; output addresses 4095,0,1.
- Reset mid-RUN after 5 issues -> next cycle all outputs 0; state IDLE; a new configure restarts cleanly; a configure pulse during RUN is ignored.
